instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//  Front end of the pocket-calculator processor: holds the PC, fetches 16-bit instructions
//  over a req/ack port and latches them in the instruction register (IR). Presents decoded
//  fields to the control unit with a valid/ready handshake.
//  imm9 feeds the sign-extension unit directly; opcode/reg_sel/br_addr feed the control unit.
//  Instruction format: [15:10] opcode, [9] reg_sel, [8:0] imm9; br_addr = IR[ADDR_W-1:0].
// PARAMETERS
//  ADDR_W    10   instruction address width (PC width)
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk        in   1       system clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  imem_req   out  1       fetch request to instruction memory
//  imem_addr  out  ADDR_W  fetch address (= pc)
//  imem_rdata in   16      instruction word, valid when imem_ack=1
//  imem_ack   in   1       memory accepts request and returns imem_rdata this cycle
//  dec_valid  out  1       decoded instruction available
//  dec_ready  in   1       control unit accepts instruction
//  opcode     out  6       IR[15:10]
//  reg_sel    out  1       IR[9]
//  imm9       out  9       IR[8:0], raw 9-bit immediate (sign in bit 8), to sign extender
//  br_addr    out  ADDR_W  IR[ADDR_W-1:0], absolute branch target field
//  pc         out  ADDR_W  address of the instruction currently in IR / being fetched
//  br_taken   in   1       redirect PC; sampled only on a transfer cycle
//  br_target  in   ADDR_W  new PC when br_taken=1 on transfer
//  halt       out  1       processor halted
// BEHAVIOUR
//  - States: IDLE, FETCH, DECODE, HALTED. All outputs registered.
//  - Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, IR=16'h0000, imem_req=0, dec_valid=0,
//    halt=0. rst overrides every other input in that cycle.
//  - IDLE: one cycle, then FETCH.
//  - FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. Ack in same cycle req rises
//    is legal. On ack edge: IR<=imem_rdata, state=DECODE; next cycle imem_req=0, dec_valid=1.
//    Latency ack -> dec_valid: 1 cycle. imem_ack while imem_req=0 is ignored.
//  - DECODE: dec_valid=1; IR, pc and all field outputs stable while dec_ready=0.
//    Transfer = dec_valid & dec_ready. On transfer:
//      opcode==6'h00 (HLT): state=HALTED, halt=1, pc unchanged, br_taken ignored.
//      else br_taken=1: pc<=br_target; else pc<=pc+1, modulo 2^ADDR_W (max wraps to 0).
//      dec_valid=0 next cycle, state=FETCH (req rises next cycle).
//  - br_taken/br_target ignored outside transfer cycles.
//  - Throughput: at most one instruction per 2 cycles (no fetch overlaps DECODE).
//  - HALTED: imem_req=0, dec_valid=0, halt=1; exit only via rst.
//  - Reset mid-fetch or mid-decode: pending request/instruction discarded; restart from
//    RESET_PC via IDLE.
// TESTING
//  1. rst 2 cycles, mem acks 2 cycles after req with 16'h0BFB -> imem_addr=0, dec_valid 1 cycle
//     after ack, opcode=6'h02, reg_sel=1, imm9=9'h1FB, pc=0.
//  2. dec_ready=0 for 5 cycles -> all outputs stable, imem_req=0; dec_ready=1 -> next cycle
//     dec_valid=0, then imem_req=1 with imem_addr=1.
//  3. br_taken=1, br_target=10'h155 on transfer -> next fetch imem_addr=10'h155; br_taken=1
//     while dec_ready=0 has no effect.
//  4. RESET_PC=10'h3FF, non-HLT instruction, no branch -> second fetch imem_addr=10'h000.
//  5. Fetch 16'h0000 -> dec_valid, on transfer halt=1, imem_req=0 for 20 cycles; rst -> halt=0,
//     fetch restarts at RESET_PC.
//  6. rst while imem_req=1 awaiting ack, ack driven during rst cycle -> next cycle imem_req=0,
//     dec_valid=0, pc=RESET_PC, IR unchanged by the ack (opcode=0).

Source files
------------

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: PC/IR front end fetching 16-bit words over req/ack and presenting decoded fields via valid/ready.
module instr_fetch_decode #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [5:0]        opcode,
  output logic              reg_sel,
  output logic [8:0]        imm9,
  output logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halt
);
  typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALTED} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              req_q, req_d, valid_q, valid_d, halt_q, halt_d;
  logic              xfer;
  assign xfer = valid_q & dec_ready;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      DECODE: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (ir_q[15:10] == 6'h00) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else begin
            state_d = FETCH;
            req_d   = 1'b1;
            pc_d    = br_taken ? br_target : pc_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        halt_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end
  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign dec_valid = valid_q;
  assign halt      = halt_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[15:10];
  assign reg_sel   = ir_q[9];
  assign imm9      = ir_q[8:0];
  assign br_addr   = ir_q[ADDR_W-1:0];
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: scoreboard bench; a second instance with RESET_PC=3FF runs in lockstep for PC wrap.
module tb_instr_fetch_decode;
  logic        clk = 0, rst = 1;
  logic [15:0] imem_rdata = 0;
  logic        imem_ack = 0, dec_ready = 0, br_taken = 0;
  logic [9:0]  br_target = 0;
  logic        imem_req, dec_valid, reg_sel, halt;
  logic [9:0]  imem_addr, br_addr, pc;
  logic [5:0]  opcode;
  logic [8:0]  imm9;
  logic        w_req, w_valid, w_reg_sel, w_halt;
  logic [9:0]  w_addr, w_br_addr, w_pc;
  logic [5:0]  w_opcode;
  logic [8:0]  w_imm9;
  typedef struct {logic [15:0] w; logic [9:0] pc;} exp_t;
  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  logic [9:0]  exp_pc = 10'h000, w_exp_pc = 10'h3FF;
  logic [15:0] cur_w = 0;

  always #5 clk = ~clk;

  instr_fetch_decode u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .dec_valid(dec_valid), .dec_ready(dec_ready), .opcode(opcode),
    .reg_sel(reg_sel), .imm9(imm9), .br_addr(br_addr), .pc(pc), .br_taken(br_taken),
    .br_target(br_target), .halt(halt));

  instr_fetch_decode #(.ADDR_W(10), .RESET_PC(10'h3FF)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .dec_valid(w_valid), .dec_ready(dec_ready), .opcode(w_opcode),
    .reg_sel(w_reg_sel), .imm9(w_imm9), .br_addr(w_br_addr), .pc(w_pc), .br_taken(br_taken),
    .br_target(br_target), .halt(w_halt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    check("req_timeout", imem_req, 1);
  endtask

  task automatic fetch(input logic [15:0] w, input int delay);
    exp_t e;
    wait_req();
    check("fetch_addr", imem_addr, exp_pc);
    check("wrap_addr", w_addr, w_exp_pc);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("addr_stable", imem_addr, exp_pc);
      check("req_held", imem_req, 1);
    end
    imem_rdata = w;
    imem_ack   = 1;
    sb.push_back('{w, exp_pc});
    @(negedge clk);
    imem_ack   = 0;
    imem_rdata = 16'h0;
    check("valid_lat", dec_valid, 1);
    check("req_drop", imem_req, 0);
    if (sb.size() == 0) check("sb_empty", 0, 1);
    else begin
      e = sb.pop_front();
      cur_w = e.w;
      check("opcode", opcode, e.w[15:10]);
      check("reg_sel", reg_sel, e.w[9]);
      check("imm9", imm9, e.w[8:0]);
      check("br_addr", br_addr, e.w[9:0]);
      check("dec_pc", pc, e.pc);
    end
  endtask

  task automatic xfer(input logic take, input logic [9:0] tgt, input int hold);
    for (int i = 0; i < hold; i++) begin
      dec_ready  = 0;
      br_taken   = 1;
      br_target  = 10'h2AA;
      imem_ack   = 1;
      imem_rdata = 16'hFFFF;
      @(negedge clk);
      check("hold_valid", dec_valid, 1);
      check("hold_req", imem_req, 0);
      check("hold_pc", pc, exp_pc);
      check("hold_ir", {opcode, reg_sel, imm9}, cur_w);
    end
    imem_ack   = 0;
    imem_rdata = 16'h0;
    dec_ready  = 1;
    br_taken   = take;
    br_target  = tgt;
    @(negedge clk);
    dec_ready = 0;
    br_taken  = 0;
    check("xfer_valid", dec_valid, 0);
    if (cur_w[15:10] == 6'h00) begin
      check("halt_set", halt, 1);
      check("halt_req", imem_req, 0);
      check("halt_pc", pc, exp_pc);
    end else begin
      exp_pc   = take ? tgt : exp_pc + 10'd1;
      w_exp_pc = take ? tgt : w_exp_pc + 10'd1;
      check("next_pc", pc, exp_pc);
      check("wrap_pc", w_pc, w_exp_pc);
      check("no_halt", halt, 0);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", dec_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_pc", pc, 0);
    check("rst_wpc", w_pc, 10'h3FF);
    rst = 0;
    exp_pc   = 10'h000;
    w_exp_pc = 10'h3FF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset(2);
    check("rst_opcode", opcode, 0);
    fetch(16'h0BFB, 2);
    check("t1_opcode", opcode, 6'h02);
    check("t1_imm9", imm9, 9'h1FB);
    xfer(0, 10'h0, 5);
    fetch(16'h1234, 0);
    xfer(1, 10'h155, 3);
    fetch(16'hFC01, 1);
    xfer(0, 10'h0, 0);
    fetch(16'h8000, 0);
    xfer(1, 10'h3FF, 1);
    fetch(16'h4001, 0);
    xfer(0, 10'h0, 0);
    check("dut_wrap", pc, 10'h000);
    fetch(16'h0000, 1);
    xfer(1, 10'h2AA, 0);
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      @(negedge clk);
      check("halted_req", imem_req, 0);
      check("halted_valid", dec_valid, 0);
      check("halted_flag", halt, 1);
    end
    imem_ack = 0;
    do_reset(1);
    fetch(16'h0BFB, 0);
    xfer(0, 10'h0, 0);
    wait_req();
    rst        = 1;
    imem_ack   = 1;
    imem_rdata = 16'hFFFF;
    @(negedge clk);
    rst      = 0;
    imem_ack = 0;
    check("rst_fetch_req", imem_req, 0);
    check("rst_fetch_valid", dec_valid, 0);
    check("rst_fetch_pc", pc, 0);
    check("rst_fetch_ir", opcode, 0);
    exp_pc   = 10'h000;
    w_exp_pc = 10'h3FF;
    fetch(16'h0BFB, 2);
    xfer(0, 10'h0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
